// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared opcode encodings for the branch resolve unit
package branch_resolve_unit_pkg;

  localparam int OP_W = 4;

  // Execute-stage branch/jump opcodes; every other 4-bit value is illegal here.
  localparam logic [OP_W-1:0] EXE_BEQ_OP  = 4'h0;
  localparam logic [OP_W-1:0] EXE_BNE_OP  = 4'h1;
  localparam logic [OP_W-1:0] EXE_BLT_OP  = 4'h2;
  localparam logic [OP_W-1:0] EXE_BGE_OP  = 4'h3;
  localparam logic [OP_W-1:0] EXE_BLTU_OP = 4'h4;
  localparam logic [OP_W-1:0] EXE_BGEU_OP = 4'h5;
  localparam logic [OP_W-1:0] EXE_JAL_OP  = 4'h6;
  localparam logic [OP_W-1:0] EXE_JALR_OP = 4'h7;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - uop request / resolved result handshake bundle
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_link;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, in_pred_target,
    output out_ready,
    input  in_ready,
    input  out_valid, out_taken, out_target, out_link, out_mispredict, out_redirect_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, in_pred_target,
    input  out_ready,
    output in_ready,
    output out_valid, out_taken, out_target, out_link, out_mispredict, out_redirect_pc, out_illegal
  );

endinterface

// File: rtl/branch_resolve_unit_cmp.sv
// rtl/branch_resolve_unit_cmp.sv - combinational direction decision and opcode legality
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o,
  output logic            illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      EXE_BEQ_OP:  taken_o = (rs1_i == rs2_i);
      EXE_BNE_OP:  taken_o = (rs1_i != rs2_i);
      EXE_BLT_OP:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      EXE_BGE_OP:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      EXE_BLTU_OP: taken_o = (rs1_i <  rs2_i);
      EXE_BGEU_OP: taken_o = (rs1_i >= rs2_i);
      EXE_JAL_OP,
      EXE_JALR_OP: taken_o = 1'b1;
      default:     illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - two-stage branch/jump resolution with flow control and counters
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 cnt_clr,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]     cnt_branches,
  output logic [CNT_W-1:0]     cnt_mispredicts
);

  logic            s1_valid_q, s1_valid_d;
  logic [OP_W-1:0] s1_op_q;
  logic [XLEN-1:0] s1_rs1_q, s1_rs2_q, s1_pc_q, s1_imm_q, s1_pred_target_q;
  logic            s1_pred_taken_q;

  logic            s2_valid_q, s2_valid_d;
  logic            s2_taken_q, s2_mispredict_q, s2_illegal_q;
  logic [XLEN-1:0] s2_target_q, s2_link_q, s2_redirect_q;

  logic [CNT_W-1:0] cnt_br_q, cnt_br_d, cnt_mp_q, cnt_mp_d;

  logic s2_adv, in_fire, s2_load, cnt_inc;

  assign s2_adv      = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !flush && (!s1_valid_q || s2_adv);
  assign in_fire     = bus.in_valid && bus.in_ready;
  assign s2_load     = !flush && s2_adv && s1_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (bus.in_ready) s1_valid_d = bus.in_valid;
      if (s2_adv)       s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q       <= 1'b0;
      s1_op_q          <= '0;
      s1_rs1_q         <= '0;
      s1_rs2_q         <= '0;
      s1_pc_q          <= '0;
      s1_imm_q         <= '0;
      s1_pred_taken_q  <= 1'b0;
      s1_pred_target_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_op_q          <= bus.in_op;
        s1_rs1_q         <= bus.in_rs1;
        s1_rs2_q         <= bus.in_rs2;
        s1_pc_q          <= bus.in_pc;
        s1_imm_q         <= bus.in_imm;
        s1_pred_taken_q  <= bus.in_pred_taken;
        s1_pred_target_q <= bus.in_pred_target;
      end
    end
  end

  logic            cmp_taken, cmp_illegal;
  logic [XLEN-1:0] br_sum, jalr_sum, res_target, res_link, res_redirect;
  logic            res_mispredict;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .op_i      (s1_op_q),
    .rs1_i     (s1_rs1_q),
    .rs2_i     (s1_rs2_q),
    .taken_o   (cmp_taken),
    .illegal_o (cmp_illegal)
  );

  // Illegal ops fall out naturally: not JALR so target is pc+imm, and taken=0 so redirect is pc+4.
  assign br_sum         = s1_pc_q + s1_imm_q;
  assign jalr_sum       = s1_rs1_q + s1_imm_q;
  assign res_target     = (s1_op_q == EXE_JALR_OP) ? (jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1}) : br_sum;
  assign res_link       = s1_pc_q + XLEN'(4);
  assign res_redirect   = cmp_taken ? res_target : res_link;
  assign res_mispredict = !cmp_illegal &&
                          ((cmp_taken != s1_pred_taken_q) ||
                           (cmp_taken && (res_target != s1_pred_target_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q      <= 1'b0;
      s2_taken_q      <= 1'b0;
      s2_mispredict_q <= 1'b0;
      s2_illegal_q    <= 1'b0;
      s2_target_q     <= '0;
      s2_link_q       <= '0;
      s2_redirect_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_taken_q      <= cmp_taken;
        s2_mispredict_q <= res_mispredict;
        s2_illegal_q    <= cmp_illegal;
        s2_target_q     <= res_target;
        s2_link_q       <= res_link;
        s2_redirect_q   <= res_redirect;
      end
    end
  end

  assign bus.out_valid       = s2_valid_q;
  assign bus.out_taken       = s2_taken_q;
  assign bus.out_target      = s2_target_q;
  assign bus.out_link        = s2_link_q;
  assign bus.out_mispredict  = s2_mispredict_q;
  assign bus.out_redirect_pc = s2_redirect_q;
  assign bus.out_illegal     = s2_illegal_q;

  // A flushed handshake is not a retirement, so it never counts.
  assign cnt_inc = s2_valid_q && bus.out_ready && !s2_illegal_q && !flush;

  always_comb begin
    cnt_br_d = cnt_br_q;
    cnt_mp_d = cnt_mp_q;
    if (cnt_clr) begin
      cnt_br_d = '0;
      cnt_mp_d = '0;
    end else if (cnt_inc) begin
      if (cnt_br_q != '1)                      cnt_br_d = cnt_br_q + CNT_W'(1);
      if (s2_mispredict_q && (cnt_mp_q != '1)) cnt_mp_d = cnt_mp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_br_q <= '0;
      cnt_mp_q <= '0;
    end else begin
      cnt_br_q <= cnt_br_d;
      cnt_mp_q <= cnt_mp_d;
    end
  end

  assign cnt_branches    = cnt_br_q;
  assign cnt_mispredicts = cnt_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed vectors, pipeline corner sequences and randomized model check
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic cnt_clr = 1'b0;
  logic [CNT_W-1:0] cnt_branches, cnt_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(XLEN)) bif ();

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .cnt_clr         (cnt_clr),
    .bus             (bif),
    .cnt_branches    (cnt_branches),
    .cnt_mispredicts (cnt_mispredicts)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pt;
    logic [31:0] ptgt;
  } uop_t;

  typedef struct {
    logic        taken;
    logic [31:0] target, link;
    logic        misp;
    logic [31:0] redirect;
    logic        ill;
  } res_t;

  typedef struct { uop_t u; res_t r; } vec_t;
  typedef struct { res_t r; int acc; } inflight_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    check({tag, ".taken"},    bif.out_taken,       e.taken);
    check({tag, ".target"},   bif.out_target,      e.target);
    check({tag, ".link"},     bif.out_link,        e.link);
    check({tag, ".misp"},     bif.out_mispredict,  e.misp);
    check({tag, ".redirect"}, bif.out_redirect_pc, e.redirect);
    check({tag, ".illegal"},  bif.out_illegal,     e.ill);
  endtask

  // Reference: direction from integer comparisons, 32-bit wrap from truncating 64-bit sums.
  function automatic res_t model(input uop_t u);
    res_t r;
    longint s1 = longint'(int'(u.rs1));
    longint s2 = longint'(int'(u.rs2));
    longint u1 = longint'(u.rs1);
    longint u2 = longint'(u.rs2);
    bit legal = 1'b1;
    bit t = 1'b0;
    case (u.op)
      EXE_BEQ_OP:  t = (u1 == u2);
      EXE_BNE_OP:  t = (u1 != u2);
      EXE_BLT_OP:  t = (s1 < s2);
      EXE_BGE_OP:  t = (s1 >= s2);
      EXE_BLTU_OP: t = (u1 < u2);
      EXE_BGEU_OP: t = (u1 >= u2);
      EXE_JAL_OP, EXE_JALR_OP: t = 1'b1;
      default: legal = 1'b0;
    endcase
    if (u.op == EXE_JALR_OP) r.target = 32'((u1 + longint'(u.imm)) / 2 * 2);
    else                     r.target = 32'(longint'(u.pc) + longint'(u.imm));
    r.link     = 32'(longint'(u.pc) + 4);
    r.taken    = t;
    r.ill      = !legal;
    r.misp     = legal && ((t != u.pt) || (t && r.target != u.ptgt));
    r.redirect = t ? r.target : r.link;
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rs1, rs2, pc, imm,
                              input logic pt, input logic [31:0] ptgt,
                              input logic tk, input logic [31:0] tgt, lnk,
                              input logic mp, input logic [31:0] rd, input logic il);
    vec_t v;
    v.u = '{op: op, rs1: rs1, rs2: rs2, pc: pc, imm: imm, pt: pt, ptgt: ptgt};
    v.r = '{taken: tk, target: tgt, link: lnk, misp: mp, redirect: rd, ill: il};
    return v;
  endfunction

  task automatic drive(input uop_t u, input logic v);
    bif.in_valid       = v;
    bif.in_op          = u.op;
    bif.in_rs1         = u.rs1;
    bif.in_rs2         = u.rs2;
    bif.in_pc          = u.pc;
    bif.in_imm         = u.imm;
    bif.in_pred_taken  = u.pt;
    bif.in_pred_target = u.ptgt;
  endtask

  function automatic uop_t beq(input logic [31:0] pc, input logic [31:0] rs2);
    uop_t u;
    u = '{op: EXE_BEQ_OP, rs1: 32'h1, rs2: rs2, pc: pc, imm: 32'h40, pt: 1'b1, ptgt: 32'h0};
    return u;
  endfunction

  vec_t tbl[11];
  int exp_br, exp_mp;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    uop_t u;
    logic [31:0] got[$];
    logic [31:0] pcs[3];
    inflight_t q[$];
    int cyc;
    bit acc, fire_in, fire_out, exp_ready, exp_ov;

    bif.out_ready = 1'b0;
    u = beq(32'h0, 32'h0);
    drive(u, 1'b0);

    tbl[0]  = mk(EXE_BLT_OP,  32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1, 32'h120,  1, 32'h120, 32'h104, 0, 32'h120, 0);
    tbl[1]  = mk(EXE_BLTU_OP, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1, 32'h120,  0, 32'h120, 32'h104, 1, 32'h104, 0);
    tbl[2]  = mk(EXE_JALR_OP, 32'h1001, 32'h0, 32'h200, 32'h4, 1, 32'h1004,        1, 32'h1004, 32'h204, 0, 32'h1004, 0);
    tbl[3]  = mk(EXE_JALR_OP, 32'h1001, 32'h0, 32'h200, 32'h4, 1, 32'h1000,        1, 32'h1004, 32'h204, 1, 32'h1004, 0);
    tbl[4]  = mk(4'hF,        32'h5, 32'h5, 32'h300, 32'h10, 1, 32'h0,              0, 32'h310, 32'h304, 0, 32'h304, 1);
    tbl[5]  = mk(EXE_JAL_OP,  32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8, 0, 32'h0,         1, 32'h4, 32'h0, 1, 32'h4, 0);
    tbl[6]  = mk(EXE_BEQ_OP,  32'h5, 32'h5, 32'h40, 32'hFFFF_FFF8, 1, 32'h38,       1, 32'h38, 32'h44, 0, 32'h38, 0);
    tbl[7]  = mk(EXE_BNE_OP,  32'h5, 32'h5, 32'h40, 32'h10, 0, 32'h0,               0, 32'h50, 32'h44, 0, 32'h44, 0);
    tbl[8]  = mk(EXE_BGE_OP,  32'h8000_0000, 32'h0, 32'h1000, 32'h10, 0, 32'h0,     0, 32'h1010, 32'h1004, 0, 32'h1004, 0);
    tbl[9]  = mk(EXE_BGEU_OP, 32'h8000_0000, 32'h0, 32'h1000, 32'h10, 0, 32'h0,     1, 32'h1010, 32'h1004, 1, 32'h1010, 0);
    tbl[10] = mk(EXE_BGE_OP,  32'h7, 32'h7, 32'h2000, 32'h100, 1, 32'h999,          1, 32'h2100, 32'h2004, 1, 32'h2100, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.out_valid", bif.out_valid, 0);
    check("rst.in_ready", bif.in_ready, 1);
    check("rst.out_target", bif.out_target, 0);
    check("rst.out_misp", bif.out_mispredict, 0);
    check("rst.cnt_br", cnt_branches, 0);
    check("rst.cnt_mp", cnt_mispredicts, 0);
    rst_n = 1'b1;

    // Directed table, one uop at a time
    exp_br = 0;
    exp_mp = 0;
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].u, 1'b1);
      bif.out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d.in_ready", i), bif.in_ready, 1);
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d.early_valid", i), bif.out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d.out_valid", i), bif.out_valid, 1);
      check_res($sformatf("v%0d", i), tbl[i].r);
      if (!tbl[i].r.ill) begin
        exp_br = (exp_br < CMAX) ? exp_br + 1 : CMAX;
        if (tbl[i].r.misp) exp_mp = (exp_mp < CMAX) ? exp_mp + 1 : CMAX;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("tbl.cnt_br", cnt_branches, 64'(exp_br));
    check("tbl.cnt_mp", cnt_mispredicts, 64'(exp_mp));

    // Backpressure: third uop refused, outputs frozen, ordered drain
    pcs[0] = 32'h500; pcs[1] = 32'h510; pcs[2] = 32'h520;
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    drive(beq(pcs[0], 32'h1), 1'b1);
    @(negedge clk);
    check("bp.ready0", bif.in_ready, 1);
    @(posedge clk); #1;
    drive(beq(pcs[1], 32'h1), 1'b1);
    @(negedge clk);
    check("bp.ready1", bif.in_ready, 1);
    @(posedge clk); #1;
    drive(beq(pcs[2], 32'h1), 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp.ready_drop%0d", k), bif.in_ready, 0);
      check($sformatf("bp.hold_valid%0d", k), bif.out_valid, 1);
      check($sformatf("bp.hold_link%0d", k), bif.out_link, 32'h504);
      @(posedge clk);
    end
    #1 bif.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bif.out_valid) got.push_back(bif.out_link);
      acc = bif.in_valid && bif.in_ready;
      @(posedge clk); #1;
      if (acc) bif.in_valid = 1'b0;
    end
    check("bp.drain_count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("bp.drain_order%0d", k), (got.size() > k) ? got[k] : 32'hDEAD_BEEF, pcs[k] + 4);

    // Flush with two uops in flight
    cnt_clr = 1'b1;
    bif.out_ready = 1'b0;
    drive(beq(32'h600, 32'h1), 1'b1);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    drive(beq(32'h610, 32'h1), 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    bif.out_ready = 1'b1;
    drive(beq(32'h620, 32'h1), 1'b1);
    @(negedge clk);
    check("fl.in_ready", bif.in_ready, 0);
    check("fl.pre_valid", bif.out_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    bif.in_valid = 1'b0;
    @(negedge clk);
    check("fl.out_valid", bif.out_valid, 0);
    check("fl.cnt_br", cnt_branches, 0);
    @(posedge clk);
    @(negedge clk);
    check("fl.no_ghost", bif.out_valid, 0);

    // Counter saturation with 16 mispredicted branches
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      drive(beq(32'h700 + 32'(k * 4), 32'h2), 1'b1);
      @(posedge clk); #1;
    end
    bif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat.cnt_br", cnt_branches, 4'hF);
    check("sat.cnt_mp", cnt_mispredicts, 4'hF);

    // Clear coincident with a counted handshake
    @(posedge clk); #1;
    drive(beq(32'h800, 32'h2), 1'b1);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("clr.out_valid", bif.out_valid, 1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr.cnt_br", cnt_branches, 0);
    check("clr.cnt_mp", cnt_mispredicts, 0);

    // Asynchronous reset with uops in flight
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    drive(beq(32'h900, 32'h1), 1'b1);
    @(posedge clk); #1;
    drive(beq(32'h904, 32'h1), 1'b1);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid", bif.out_valid, 0);
    check("arst.out_link", bif.out_link, 0);
    check("arst.in_ready", bif.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    exp_br = 0;
    exp_mp = 0;
    cyc = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      u.op   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      u.rs1  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      u.rs2  = ($urandom_range(0, 2) == 0) ? u.rs1 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom);
      u.pc   = $urandom;
      u.imm  = $urandom;
      u.pt   = 1'($urandom_range(0, 1));
      u.ptgt = 32'h0;
      u.ptgt = ($urandom_range(0, 1) == 0) ? model(u).target : $urandom;
      drive(u, ($urandom_range(0, 3) != 0));
      bif.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      exp_ready = !flush && !(q.size() == 2 && !bif.out_ready);
      exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
      check($sformatf("rnd%0d.in_ready", n), bif.in_ready, exp_ready);
      check($sformatf("rnd%0d.out_valid", n), bif.out_valid, exp_ov);
      check($sformatf("rnd%0d.cnt_br", n), cnt_branches, 64'(exp_br));
      check($sformatf("rnd%0d.cnt_mp", n), cnt_mispredicts, 64'(exp_mp));
      if (bif.out_valid && q.size() > 0) check_res($sformatf("rnd%0d", n), q[0].r);
      fire_out = bif.out_valid && bif.out_ready && q.size() > 0;
      fire_in  = bif.in_valid && bif.in_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (fire_out) begin
          if (!q[0].r.ill) begin
            exp_br = (exp_br < CMAX) ? exp_br + 1 : CMAX;
            if (q[0].r.misp) exp_mp = (exp_mp < CMAX) ? exp_mp + 1 : CMAX;
          end
          void'(q.pop_front());
        end
        if (fire_in) q.push_back('{r: model(u), acc: cyc});
      end
      cyc++;
    end
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
